genius_param_ctrl: RTL and testbench
====================================

# genius_param_ctrl

Parametrised Genius (Simon) game controller with the display and input timers built in. It stores a random colour sequence of up to MAX_LEN entries and plays the round back to the VGA colour path. It then checks the player's button presses against the stored sequence, extends the sequence after every completed round, and declares a win or a loss. A configurable speed-up mode shortens the display time after each completed round.

## Interface
Parameters:
- COLOR_W, 2: colour code width; 2^COLOR_W colours.
- MAX_LEN, 16: maximum sequence length; reaching it wins. Must be ≥1.
- SHOW_CYC, 50_000_000: initial on-time per colour during playback, in cycles. Must be ≥1.
- GAP_CYC, 12_500_000: blank time between playback colours, in cycles. Must be ≥1.
- ECHO_CYC, 12_500_000: on-time of the echo of a player's press, in cycles. Must be ≥1.
- INPUT_CYC, 250_000_000: timeout for each player press, in cycles. Must be ≥1.
- SHOW_STEP, 0: show-time decrement per completed round. 0 disables speed-up.
- SHOW_MIN, 12_500_000: floor for the show time. Must satisfy 1 ≤ SHOW_MIN ≤ SHOW_CYC.

Ports:
- CLK, in, 1: clock.
- RESET, in, 1: synchronous, active-high.
- START, in, 1: one-cycle pulse; starts a new game.
- RND_COLOR, in, COLOR_W: random colour, sampled in ADD.
- BTN_VALID, in, 1: one-cycle strobe marking a decoded player press.
- BTN_COLOR, in, COLOR_W: colour of the press; valid only when BTN_VALID=1.
- VGA_COLOR, out, COLOR_W: colour to draw.
- VGA_FLAG, out, 1: draw VGA_COLOR this cycle.
- VGA_LOSE, out, 1: loss screen.
- VGA_WIN, out, 1: win screen.
- SCORE, out, $clog2(MAX_LEN+1): number of completed rounds.
- STATE, out, 3: current state encoding (for debug).

## Operation
- States and encodings: IDLE=0, ADD=1, SHOW_ON=2, SHOW_GAP=3, WAIT_IN=4, ECHO=5, LOSE=6, WIN=7.
- Storage: MAX_LEN×COLOR_W register array mem.
- Counters:
  - LEN: $clog2(MAX_LEN+1) bits, current round length.
  - idx: position within the round.
  - tmr: wide enough for the largest duration parameter.
  - show_t: current show time.
- IDLE, LOSE, WIN with START=1: LEN←0, SCORE←0, show_t←SHOW_CYC, next state ADD.
- START is ignored in every other state.
- ADD (1 cycle): mem[LEN]←RND_COLOR, LEN←LEN+1, idx←0, tmr←0, next state SHOW_ON.
- SHOW_ON: VGA_FLAG=1, VGA_COLOR=mem[idx].
  - Lasts exactly show_t cycles, ending when tmr==show_t−1.
  - Then tmr←0, next state SHOW_GAP.
- SHOW_GAP: VGA_FLAG=0; lasts exactly GAP_CYC cycles.
  - If idx==LEN−1: idx←0, next state WAIT_IN.
  - Otherwise: idx←idx+1, next state SHOW_ON.
- WAIT_IN: tmr counts up from 0.
  - BTN_VALID with BTN_COLOR==mem[idx]: latch the colour, tmr←0, next state ECHO.
  - BTN_VALID with a mismatch: next state LOSE.
  - No BTN_VALID when tmr==INPUT_CYC−1: next state LOSE (timeout).
  - If BTN_VALID arrives in the timeout cycle, the press takes priority over the timeout.
- ECHO: VGA_FLAG=1, VGA_COLOR=latched colour; lasts exactly ECHO_CYC cycles. BTN_VALID is ignored.
- End of ECHO:
  - idx<LEN−1: idx←idx+1, tmr←0, next state WAIT_IN.
  - idx==LEN−1, round complete: SCORE←LEN, then:
    - LEN==MAX_LEN: next state WIN.
    - Otherwise: show_t←max(show_t−SHOW_STEP, SHOW_MIN) with saturating subtraction (no underflow), next state ADD.
- LOSE: VGA_LOSE=1. WIN: VGA_WIN=1. Both hold until START or RESET.
- Outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- VGA_COLOR is 0 whenever VGA_FLAG=0.

## Timing
- Reset values: state IDLE, all outputs 0 (VGA_COLOR, VGA_FLAG, VGA_LOSE, VGA_WIN, SCORE, STATE), LEN=0, idx=0, tmr=0, show_t=SHOW_CYC.
- mem is not cleared on reset.
- RESET asserted in any state, mid-playback or mid-input included, returns everything to the reset values on the next edge. RESET overrides START and BTN_VALID.
- START→ADD: 1 cycle. ADD→first SHOW_ON: 1 cycle.
- Playback of a round of length L: L·(show_t+GAP_CYC) cycles.
- WAIT_IN reaction: the state changes on the edge after the BTN_VALID cycle.
- Last ECHO of a round to ADD: 1 cycle.
- tmr restarts at 0 on every entry to SHOW_ON, SHOW_GAP, WAIT_IN and ECHO.

## Test plan
All scenarios use MAX_LEN=3, SHOW_CYC=4, GAP_CYC=2, ECHO_CYC=2, INPUT_CYC=8, SHOW_STEP=1, SHOW_MIN=3.
- Reset then START with RND_COLOR=2 → ADD for 1 cycle, then VGA_FLAG=1 with VGA_COLOR=2 for exactly 4 cycles, then 2 blank cycles, then WAIT_IN.
- Round 1: press 2 → ECHO for 2 cycles, then SCORE=1, ADD. Round 2 playback uses show_t=3: VGA_FLAG high for 3 cycles per colour.
- Wrong colour in WAIT_IN → LOSE on the next cycle, VGA_LOSE=1. START → ADD with SCORE=0 and LEN restarting at 1.
- No press for 8 cycles → LOSE. A press in cycle 8 (tmr=7) → ECHO, not LOSE.
- Three correct rounds → WIN, VGA_WIN=1, SCORE=3. The show time never drops below 3.
- RESET pulsed during SHOW_ON of round 2 → all outputs 0, STATE=0. START afterwards begins a fresh game.

Source files
------------

// File: rtl/genius_param_ctrl.sv
// Genius (Simon) game controller: sequence store, playback,
// input checking, scoring and optional speed-up between rounds.
module genius_param_ctrl #(
  parameter int COLOR_W   = 2,
  parameter int MAX_LEN   = 16,
  parameter int SHOW_CYC  = 50_000_000,
  parameter int GAP_CYC   = 12_500_000,
  parameter int ECHO_CYC  = 12_500_000,
  parameter int INPUT_CYC = 250_000_000,
  parameter int SHOW_STEP = 0,
  parameter int SHOW_MIN  = 12_500_000
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           START,
  input  logic [COLOR_W-1:0]             RND_COLOR,
  input  logic                           BTN_VALID,
  input  logic [COLOR_W-1:0]             BTN_COLOR,
  output logic [COLOR_W-1:0]             VGA_COLOR,
  output logic                           VGA_FLAG,
  output logic                           VGA_LOSE,
  output logic                           VGA_WIN,
  output logic [$clog2(MAX_LEN+1)-1:0]   SCORE,
  output logic [2:0]                     STATE
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  // Timer must hold the longest duration (and the step, for the
  // saturating show-time arithmetic).
  localparam int M1 = (SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC;
  localparam int M2 = (ECHO_CYC > INPUT_CYC) ? ECHO_CYC : INPUT_CYC;
  localparam int M3 = (M1 > M2) ? M1 : M2;
  localparam int MD = (M3 > SHOW_STEP) ? M3 : SHOW_STEP;
  localparam int TW = $clog2(MD + 1);

  localparam logic [TW-1:0] GAP_END  = TW'(GAP_CYC - 1);
  localparam logic [TW-1:0] ECHO_END = TW'(ECHO_CYC - 1);
  localparam logic [TW-1:0] IN_END   = TW'(INPUT_CYC - 1);
  localparam logic [TW-1:0] SHOW_INI = TW'(SHOW_CYC);
  localparam logic [TW-1:0] MIN_T    = TW'(SHOW_MIN);
  localparam logic [TW-1:0] STEP_T   = TW'(SHOW_STEP);
  localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADD      = 3'd1,
    S_SHOW_ON  = 3'd2,
    S_SHOW_GAP = 3'd3,
    S_WAIT_IN  = 3'd4,
    S_ECHO     = 3'd5,
    S_LOSE     = 3'd6,
    S_WIN      = 3'd7
  } state_t;

  state_t               state;
  logic [COLOR_W-1:0]   mem [MAX_LEN];
  logic [LW-1:0]        len;
  logic [LW-1:0]        idx;
  logic [TW-1:0]        tmr;
  logic [TW-1:0]        show_t;
  logic [TW-1:0]        show_nx;
  logic [TW:0]          floor_sum;
  logic [COLOR_W-1:0]   echo_c;
  logic [LW-1:0]        score;
  logic                 last;
  logic [COLOR_W-1:0]   vga_c;

  assign last      = (idx == len - LW'(1));
  assign floor_sum = {1'b0, MIN_T} + {1'b0, STEP_T};
  assign show_nx   = ({1'b0, show_t} >= floor_sum) ?
                     (show_t - STEP_T) : MIN_T;

  // Sequence storage; deliberately not cleared by reset.
  always_ff @(posedge CLK) begin
    if (!RESET && state == S_ADD)
      mem[len[IW-1:0]] <= RND_COLOR;
  end

  // Game FSM with round, position, timer and show-time bookkeeping.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= S_IDLE;
      len    <= '0;
      idx    <= '0;
      tmr    <= '0;
      show_t <= SHOW_INI;
      echo_c <= '0;
      score  <= '0;
    end else begin
      case (state)
        S_IDLE, S_LOSE, S_WIN: begin
          if (START) begin
            len    <= '0;
            score  <= '0;
            show_t <= SHOW_INI;
            state  <= S_ADD;
          end
        end
        S_ADD: begin
          len   <= len + LW'(1);
          idx   <= '0;
          tmr   <= '0;
          state <= S_SHOW_ON;
        end
        S_SHOW_ON: begin
          if (tmr == show_t - TW'(1)) begin
            tmr   <= '0;
            state <= S_SHOW_GAP;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        S_SHOW_GAP: begin
          if (tmr == GAP_END) begin
            tmr <= '0;
            if (last) begin
              idx   <= '0;
              state <= S_WAIT_IN;
            end else begin
              idx   <= idx + LW'(1);
              state <= S_SHOW_ON;
            end
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        S_WAIT_IN: begin
          if (BTN_VALID) begin
            if (BTN_COLOR == mem[idx[IW-1:0]]) begin
              echo_c <= BTN_COLOR;
              tmr    <= '0;
              state  <= S_ECHO;
            end else begin
              state <= S_LOSE;
            end
          end else if (tmr == IN_END) begin
            state <= S_LOSE;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        S_ECHO: begin
          if (tmr == ECHO_END) begin
            tmr <= '0;
            if (!last) begin
              idx   <= idx + LW'(1);
              state <= S_WAIT_IN;
            end else begin
              score <= len;
              if (len == LEN_MAX) begin
                state <= S_WIN;
              end else begin
                show_t <= show_nx;
                state  <= S_ADD;
              end
            end
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Colour shown only while drawing; blank otherwise.
  always_comb begin
    vga_c = '0;
    case (state)
      S_SHOW_ON: vga_c = mem[idx[IW-1:0]];
      S_ECHO:    vga_c = echo_c;
      default:   vga_c = '0;
    endcase
  end

  assign VGA_COLOR = vga_c;
  assign VGA_FLAG  = (state == S_SHOW_ON) || (state == S_ECHO);
  assign VGA_LOSE  = (state == S_LOSE);
  assign VGA_WIN   = (state == S_WIN);
  assign SCORE     = score;
  assign STATE     = state;

endmodule

// File: tb/tb_genius_param_ctrl.sv
// Randomized game-level bench for genius_param_ctrl.
// Expected per-cycle outputs are queued by stimulus, checked by a monitor.
module tb_genius_param_ctrl;

  localparam int CW = 2;
  localparam int ML = 3;
  localparam int SC = 4;
  localparam int GC = 2;
  localparam int EC = 2;
  localparam int IC = 8;
  localparam int SS = 1;
  localparam int SM = 3;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       START = 1'b0;
  logic [1:0] RND_COLOR = 2'd0;
  logic       BTN_VALID = 1'b0;
  logic [1:0] BTN_COLOR = 2'd0;
  logic [1:0] VGA_COLOR;
  logic       VGA_FLAG;
  logic       VGA_LOSE;
  logic       VGA_WIN;
  logic [1:0] SCORE;
  logic [2:0] STATE;

  genius_param_ctrl #(
    .COLOR_W(CW), .MAX_LEN(ML), .SHOW_CYC(SC), .GAP_CYC(GC),
    .ECHO_CYC(EC), .INPUT_CYC(IC), .SHOW_STEP(SS), .SHOW_MIN(SM)
  ) dut (
    .CLK(CLK), .RESET(RESET), .START(START),
    .RND_COLOR(RND_COLOR), .BTN_VALID(BTN_VALID),
    .BTN_COLOR(BTN_COLOR), .VGA_COLOR(VGA_COLOR),
    .VGA_FLAG(VGA_FLAG), .VGA_LOSE(VGA_LOSE), .VGA_WIN(VGA_WIN),
    .SCORE(SCORE), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0] st;
    logic       f;
    logic [1:0] c;
    logic       lo;
    logic       wi;
    logic [1:0] sc;
  } exp_t;

  exp_t q[$];
  exp_t got;
  exp_t ex;
  int   n_tests = 0;
  int   n_fail  = 0;

  // reference model: game-level view
  int seq[$];
  int show_t = SC;
  int score  = 0;
  bit first_rc = 1'b1;

  function automatic exp_t mk(input int st, input int c);
    exp_t e;
    e.st = 3'(st);
    e.f  = (st == 2) || (st == 5);
    e.c  = e.f ? 2'(c) : 2'd0;
    e.lo = (st == 6);
    e.wi = (st == 7);
    e.sc = 2'(score);
    return e;
  endfunction

  function automatic logic [1:0] nz();
    return 2'($urandom);
  endfunction

  task automatic step(input logic s, input logic r, input logic bv,
                      input logic [1:0] bc, input logic [1:0] rc,
                      input exp_t e);
    @(negedge CLK);
    START     = s;
    RESET     = r;
    BTN_VALID = bv;
    BTN_COLOR = bc;
    RND_COLOR = rc;
    q.push_back(e);
  endtask

  task automatic chk_now(input exp_t e, input string tag);
    exp_t g;
    @(posedge CLK);
    #2;
    g = {STATE, VGA_FLAG, VGA_COLOR, VGA_LOSE, VGA_WIN, SCORE};
    n_tests++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s: got st=%0d flag=%0b col=%0d lose=%0b win=%0b score=%0d, want st=%0d lose=%0b score=%0d",
               tag, g.st, g.f, g.c, g.lo, g.wi, g.sc,
               e.st, e.lo, e.sc);
    end
  endtask

  // monitor: compare every cycle that has a queued expectation
  always @(posedge CLK) begin
    #1;
    if (q.size() > 0) begin
      ex  = q.pop_front();
      got = {STATE, VGA_FLAG, VGA_COLOR, VGA_LOSE, VGA_WIN, SCORE};
      n_tests++;
      if (got !== ex) begin
        n_fail++;
        $display("FAIL out#%0d: got st=%0d flag=%0b col=%0d lose=%0b win=%0b score=%0d, want st=%0d flag=%0b col=%0d lose=%0b win=%0b score=%0d",
                 n_tests, got.st, got.f, got.c, got.lo, got.wi, got.sc,
                 ex.st, ex.f, ex.c, ex.lo, ex.wi, ex.sc);
      end
    end
  end

  // quiet cycles in a state that only reacts to START/RESET
  task automatic idle(input int n, input int st);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 1'($urandom), nz(), nz(), mk(st, 0));
  endtask

  task automatic start_game();
    seq.delete();
    score  = 0;
    show_t = SC;
    step(1'b1, 1'b0, 1'($urandom), nz(), nz(), mk(1, 0));
  endtask

  // ADD cycle plus playback; optional RESET at playback step rst_at
  task automatic play_round(input int rst_at, output bit aborted);
    exp_t pl[$];
    logic [1:0] rc;
    aborted = 1'b0;
    rc = first_rc ? 2'd2 : nz();
    first_rc = 1'b0;
    seq.push_back(int'(rc));
    foreach (seq[i]) begin
      repeat (show_t) pl.push_back(mk(2, seq[i]));
      repeat (GC) pl.push_back(mk(3, 0));
    end
    pl.push_back(mk(4, 0));
    for (int k = 0; k < pl.size(); k++) begin
      if (k == rst_at) begin
        seq.delete();
        score  = 0;
        show_t = SC;
        step(1'($urandom), 1'b1, 1'($urandom), nz(), nz(), mk(0, 0));
        aborted = 1'b1;
        return;
      end
      step(1'b0, 1'b0, 1'b0, nz(), (k == 0) ? rc : nz(), pl[k]);
    end
  endtask

  // player phase; res: 0 next round, 1 lost, 2 won
  task automatic input_phase(input int mode, output int res);
    int L;
    int r;
    int d;
    L = seq.size();
    res = 0;
    for (int i = 0; i < L; i++) begin
      r = $urandom % 10;
      if (mode == 2 && i == 0) r = 0;
      if (mode == 3 && i == 0) r = 1;
      if (mode == 1 || mode == 4) r = 5;
      if (r == 1) begin
        repeat (IC - 1)
          step(1'($urandom), 1'b0, 1'b0, nz(), nz(), mk(4, 0));
        step(1'($urandom), 1'b0, 1'b0, nz(), nz(), mk(6, 0));
        chk_now(mk(6, 0), "timeout");
        res = 1;
        return;
      end
      d = ($urandom % 3 == 0) ? IC - 1 : int'($urandom % IC);
      if (mode == 4) d = IC - 1;
      repeat (d)
        step(1'($urandom), 1'b0, 1'b0, nz(), nz(), mk(4, 0));
      if (r == 0) begin
        step(1'b0, 1'b0, 1'b1, 2'((seq[i] + 1 + $urandom % 3) % 4),
             nz(), mk(6, 0));
        res = 1;
        return;
      end
      step(1'b0, 1'b0, 1'b1, 2'(seq[i]), nz(), mk(5, seq[i]));
      repeat (EC - 1)
        step(1'($urandom), 1'b0, 1'($urandom), nz(), nz(),
             mk(5, seq[i]));
      if (i < L - 1) begin
        step(1'($urandom), 1'b0, 1'($urandom), nz(), nz(), mk(4, 0));
      end else begin
        score = L;
        if (L == ML) begin
          step(1'b0, 1'b0, 1'($urandom), nz(), nz(), mk(7, 0));
          res = 2;
        end else begin
          show_t = (show_t - SS < SM) ? SM : show_t - SS;
          step(1'b0, 1'b0, 1'($urandom), nz(), nz(), mk(1, 0));
          res = 0;
        end
      end
    end
  endtask

  initial begin
    int  mode;
    int  res;
    int  rnd;
    int  rst_at;
    bit  ab;
    step(1'b1, 1'b1, 1'b1, 2'd1, 2'd3, mk(0, 0));
    chk_now(mk(0, 0), "reset");
    step(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, mk(0, 0));
    idle(2, 0);
    for (int g = 0; g < 40; g++) begin
      mode = (g < 5) ? g + 1 : 0;
      if (g >= 5 && $urandom % 8 == 0) mode = 5;
      start_game();
      rnd = 1;
      forever begin
        rst_at = -1;
        if (mode == 5 && rnd == 2)
          rst_at = 1 + int'($urandom % (show_t - 1));
        play_round(rst_at, ab);
        if (ab) begin
          idle(2, 0);
          break;
        end
        input_phase((mode == 5) ? 1 : mode, res);
        if (res != 0) begin
          idle(3, (res == 1) ? 6 : 7);
          break;
        end
        rnd++;
      end
    end
    repeat (3) @(posedge CLK);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
